// File: rtl/ft232r_rsp_arb_pkg.sv
// Shared definitions for the FT232R response-path arbiter: byte width,
// FSM state encoding and width helpers used for parameter-dependent ports.
package ft232r_rsp_arb_pkg;

  localparam int FT_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } arb_state_t;

  // Index width for n requesters; at least one bit so N=1 still has a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lock timer width; a disabled timeout still gets a 1-bit (idle) counter.
  function automatic int cnt_w(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/ft232r_rsp_arb_rr_pick.sv
// Rotate-priority encoder: first asserted request at or after ptr, wrapping
// from N-1 back to 0.
module ft232r_rsp_arb_rr_pick
  import ft232r_rsp_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [idx_w(N)-1:0]   ptr,
  output logic                  hit,
  output logic [idx_w(N)-1:0]   idx
);

  localparam int PW = idx_w(N);

  // Scan N candidates starting at ptr; the first one found wins.
  always_comb begin
    int cand;
    hit  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!hit && req[cand]) begin
        hit = 1'b1;
        idx = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/ft232r_rsp_arb.sv
// Round-robin arbiter sharing the FT232R response byte path. The grant stays
// locked to one requester until its last byte, or until the lock timer expires.
//
//   state | meaning
//   IDLE  | no grant; scan requesters from rr_ptr, latch the winner's byte
//   SEND  | rsp_req high, waiting for the serializer's rsp_ack pulse
//   ACK   | req_ack high to the holder until it drops req
//   HOLD  | mid-packet; wait for the holder's next byte, lock timer running
module ft232r_rsp_arb
  import ft232r_rsp_arb_pkg::*;
#(
  parameter int P_N_REQ        = 4,
  parameter int P_LOCK_TIMEOUT = 125000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [P_N_REQ-1:0]             req_req,
  input  logic [P_N_REQ-1:0]             req_last,
  input  logic [FT_BYTE_W*P_N_REQ-1:0]   req_data,
  output logic [P_N_REQ-1:0]             req_ack,
  output logic                           rsp_req,
  output logic [FT_BYTE_W-1:0]           rsp_data,
  input  logic                           rsp_ack,
  output logic                           gnt_vld,
  output logic [idx_w(P_N_REQ)-1:0]      gnt_idx,
  output logic                           lock_to
);

  localparam int PW = idx_w(P_N_REQ);
  localparam int TW = cnt_w(P_LOCK_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'((P_LOCK_TIMEOUT > 0) ? P_LOCK_TIMEOUT - 1 : 0);

  arb_state_t state, state_nx;
  logic [PW-1:0]        rr_ptr, rr_ptr_nx, gnt_nx, ptr_after;
  logic                 gnt_vld_nx, rsp_req_nx, last_q, last_nx, lock_to_nx;
  logic [FT_BYTE_W-1:0] rsp_data_nx;
  logic [P_N_REQ-1:0]   req_ack_nx;
  logic [TW-1:0]        to_cnt, to_cnt_nx;
  logic                 pick_hit;
  logic [PW-1:0]        pick_idx;

  ft232r_rsp_arb_rr_pick #(.N(P_N_REQ)) u_pick (
    .req (req_req),
    .ptr (rr_ptr),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  // Pointer for the next arbitration round: one past the releasing holder.
  assign ptr_after = (int'(gnt_idx) == P_N_REQ - 1) ? '0 : gnt_idx + 1'b1;

  // Next-state and registered-output logic; everything holds by default.
  always_comb begin
    state_nx    = state;
    rr_ptr_nx   = rr_ptr;
    gnt_nx      = gnt_idx;
    gnt_vld_nx  = gnt_vld;
    rsp_req_nx  = rsp_req;
    rsp_data_nx = rsp_data;
    last_nx     = last_q;
    req_ack_nx  = req_ack;
    to_cnt_nx   = to_cnt;
    lock_to_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_hit) begin
          gnt_nx      = pick_idx;
          rsp_data_nx = req_data[int'(pick_idx)*FT_BYTE_W +: FT_BYTE_W];
          last_nx     = req_last[pick_idx];
          gnt_vld_nx  = 1'b1;
          rsp_req_nx  = 1'b1;
          state_nx    = ST_SEND;
        end
      end
      ST_SEND: begin
        // A requester dropping req early does not abort the byte in flight.
        if (rsp_ack) begin
          rsp_req_nx          = 1'b0;
          req_ack_nx          = '0;
          req_ack_nx[gnt_idx] = 1'b1;
          state_nx            = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!req_req[gnt_idx]) begin
          req_ack_nx = '0;
          if (last_q) begin
            rr_ptr_nx  = ptr_after;
            gnt_vld_nx = 1'b0;
            state_nx   = ST_IDLE;
          end else begin
            to_cnt_nx = '0;
            state_nx  = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // A new byte beats a simultaneous timeout.
        if (req_req[gnt_idx]) begin
          rsp_data_nx = req_data[int'(gnt_idx)*FT_BYTE_W +: FT_BYTE_W];
          last_nx     = req_last[gnt_idx];
          rsp_req_nx  = 1'b1;
          state_nx    = ST_SEND;
        end else if (P_LOCK_TIMEOUT != 0 && to_cnt == TO_LAST) begin
          lock_to_nx = 1'b1;
          rr_ptr_nx  = ptr_after;
          gnt_vld_nx = 1'b0;
          state_nx   = ST_IDLE;
        end else if (to_cnt != '1) begin
          to_cnt_nx = to_cnt + 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      gnt_idx  <= '0;
      gnt_vld  <= 1'b0;
      rsp_req  <= 1'b0;
      rsp_data <= '0;
      last_q   <= 1'b0;
      req_ack  <= '0;
      to_cnt   <= '0;
      lock_to  <= 1'b0;
    end else begin
      state    <= state_nx;
      rr_ptr   <= rr_ptr_nx;
      gnt_idx  <= gnt_nx;
      gnt_vld  <= gnt_vld_nx;
      rsp_req  <= rsp_req_nx;
      rsp_data <= rsp_data_nx;
      last_q   <= last_nx;
      req_ack  <= req_ack_nx;
      to_cnt   <= to_cnt_nx;
      lock_to  <= lock_to_nx;
    end
  end

endmodule
